vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_RES, default 640, active pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_RES, default 480, active lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 Parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-010 Parameter CW, default 10, width of the position counters.
REQ-011 clk  in  1  50 MHz system clock; the only clock in the block.
REQ-012 rst  in  1  reset; synchronous, active-high.
REQ-013 pix_stb  out  1  one-clk pixel strobe at clk/2, which gives a 25 MHz pixel rate.
REQ-014 sx  out  CW  horizontal position, 0 to H_TOTAL-1.
REQ-015 sy  out  CW  vertical position, 0 to V_TOTAL-1.
REQ-016 hsync  out  1  horizontal sync, level per SYNC_POL.
REQ-017 vsync  out  1  vertical sync, level per SYNC_POL.
REQ-018 de  out  1  data enable, high in the active area.
REQ-019 vblank  out  1  high while sy >= V_RES; used to gate CPU access to character/VRAM.
REQ-020 frame  out  1  start-of-frame pulse.
REQ-021 line  out  1  start-of-line pulse.

Function
REQ-022 H_TOTAL = H_RES+H_FP+H_SYNC+H_BP, which is 800 with the defaults; V_TOTAL = V_RES+V_FP+V_SYNC+V_BP, which is 525 with the defaults.
REQ-023 Pixel strobe:
- Internal phase bit toggles every clk.
- pix_stb is registered and is 1 exactly on clk cycles following an edge where phase was 1; it is 0 otherwise.
REQ-024 Counter advance:
- sx, sy and all sync/de/vblank/frame/line outputs update only on the edge that sets pix_stb=1.
- They hold on every other cycle.
REQ-025 Horizontal: sx increments by 1; at sx = H_TOTAL-1 it wraps to 0.
REQ-026 Vertical:
- sy increments only when sx wraps.
- At sy = V_TOTAL-1 with sx wrap, sy wraps to 0.
REQ-027 Output alignment:
- All outputs are registered and computed from the next counter values.
- In any cycle they describe the sx/sy presented in that same cycle, with no skew between position and sync/de.
REQ-028 de = 1 iff sx < H_RES and sy < V_RES.
REQ-029 hsync active iff H_RES+H_FP <= sx <= H_RES+H_FP+H_SYNC-1, which is 656..751 with the defaults.
REQ-030 vsync active iff V_RES+V_FP <= sy <= V_RES+V_FP+V_SYNC-1, which is 490..491 with the defaults; vsync follows sy only, not sx.
REQ-031 When not active, hsync and vsync drive ~SYNC_POL.
REQ-032 frame:
- 1 only when sx=0 and sy=0.
- Asserted for the single pix_stb cycle at that position; 0 on all other clk cycles.
REQ-033 line:
- 1 when sx=0, on every line including blanking lines.
- Asserted for the single pix_stb cycle; 0 on all other clk cycles.
REQ-034 Counter arithmetic is unsigned CW-bit; no intermediate overflow for any parameter set with H_TOTAL, V_TOTAL <= 2^CW.
REQ-035 No state besides phase, sx, sy and the registered outputs; no handshake inputs; free-running after reset.

Reset
REQ-036 While rst=1 at a clk edge, the block presets the following values:
- phase=0, pix_stb=0.
- sx=H_TOTAL-1, sy=V_TOTAL-1.
- de=0, vblank=1, hsync and vsync inactive (~SYNC_POL).
- frame=0, line=0.
REQ-037 The first clk edge after rst falls:
- Leaves pix_stb=0.
- Sets phase to 1.
REQ-038 The second clk edge after rst falls produces:
- pix_stb=1.
- sx=0, sy=0.
- de=1, vblank=0.
- frame=1, line=1.
REQ-039 rst asserted mid-frame overrides any counter advance on that edge and returns all state to the REQ-036 values.

Verification
REQ-040 Reset release: hold rst 3 clks, drop it -> 2nd clk after release shows pix_stb=1, sx=0, sy=0, de=1, frame=1, line=1, vblank=0; hsync=1 and vsync=1.
REQ-041 Strobe/frame period:
- pix_stb is high on alternate clks only.
- frame pulses are exactly 840000 clks apart (2*800*525).
- 307200 pix_stb cycles with de=1 occur per frame.
REQ-042 Hsync window:
- On line sy=10, hsync=0 for exactly 96 pix_stb cycles, sx=656..751.
- hsync=1 at sx=655 and sx=752.
- line pulses exactly 1600 clks apart.
REQ-043 Vsync/vblank:
- vsync=0 from (sx=0, sy=490) through (sx=799, sy=491), i.e. 1600 pix_stb cycles.
- vblank=1 from sy=480 through sy=524.
- vblank returns to 0 with frame=1 at (0,0).
REQ-044 Wrap boundary: at (799,524) the next pix_stb shows (0,0) with frame=1; at (799,100) the next pix_stb shows (0,101) with line=1, frame=0.
REQ-045 Mid-frame reset: assert rst for 1 clk at sx=300, sy=200 -> next clk sx=799, sy=524, de=0, pix_stb=0; the 2nd clk after release shows (0,0) with frame=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator. Divides clk by two into a
//               one-clk pixel strobe and, on each strobe, advances the
//               horizontal/vertical position counters and the sync, data
//               enable, vblank and start-of-frame/line outputs.
// Ports       : clk        - system clock (pixel rate is clk/2)
//               rst        - synchronous active-high reset
//               o_pix_stb  - one-clk pixel strobe
//               o_sx/o_sy  - current pixel position
//               o_hsync    - horizontal sync, active level SYNC_POL
//               o_vsync    - vertical sync, active level SYNC_POL
//               o_de       - high inside the visible area
//               o_vblank   - high on vertical blanking lines
//               o_frame    - strobe-wide pulse at position (0,0)
//               o_line     - strobe-wide pulse at sx = 0
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_RES    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_RES    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic          o_pix_stb,
  output logic [CW-1:0] o_sx,
  output logic [CW-1:0] o_sy,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic          o_vblank,
  output logic          o_frame,
  output logic          o_line
);

  localparam int c_H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  // All boundaries are below the totals, so they fit in CW bits whenever
  // the totals do.
  localparam logic [CW-1:0] c_H_LAST  = CW'(c_H_TOTAL - 1);
  localparam logic [CW-1:0] c_V_LAST  = CW'(c_V_TOTAL - 1);
  localparam logic [CW-1:0] c_H_RES   = CW'(H_RES);
  localparam logic [CW-1:0] c_V_RES   = CW'(V_RES);
  localparam logic [CW-1:0] c_HS_BEG  = CW'(H_RES + H_FP);
  localparam logic [CW-1:0] c_HS_END  = CW'(H_RES + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] c_VS_BEG  = CW'(V_RES + V_FP);
  localparam logic [CW-1:0] c_VS_END  = CW'(V_RES + V_FP + V_SYNC - 1);
  localparam logic          c_SYNC_ON  = (SYNC_POL != 0);
  localparam logic          c_SYNC_OFF = ~c_SYNC_ON;

  logic          r_phase;
  logic          r_pix_stb;
  logic [CW-1:0] r_sx;
  logic [CW-1:0] r_sy;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  logic          r_vblank;
  logic          r_frame;
  logic          r_line;

  logic          w_h_wrap;
  logic [CW-1:0] w_sx_nx;
  logic [CW-1:0] w_sy_nx;
  logic          w_hs_act;
  logic          w_vs_act;

  // Next position; the increment is only taken below the last value, so it
  // never overflows CW bits.
  always_comb begin
    w_h_wrap = (r_sx == c_H_LAST);
    w_sx_nx  = w_h_wrap ? '0 : r_sx + CW'(1);
    w_sy_nx  = r_sy;
    if (w_h_wrap) begin
      w_sy_nx = (r_sy == c_V_LAST) ? '0 : r_sy + CW'(1);
    end
  end

  // Sync windows are decoded from the next position so the registered sync
  // lines never lag the registered counters.
  assign w_hs_act = (w_sx_nx >= c_HS_BEG) && (w_sx_nx <= c_HS_END);
  assign w_vs_act = (w_sy_nx >= c_VS_BEG) && (w_sy_nx <= c_VS_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      // Counters park on the last position so the first strobe lands on (0,0).
      r_phase   <= 1'b0;
      r_pix_stb <= 1'b0;
      r_sx      <= c_H_LAST;
      r_sy      <= c_V_LAST;
      r_hsync   <= c_SYNC_OFF;
      r_vsync   <= c_SYNC_OFF;
      r_de      <= 1'b0;
      r_vblank  <= 1'b1;
      r_frame   <= 1'b0;
      r_line    <= 1'b0;
    end else begin
      r_phase   <= ~r_phase;
      r_pix_stb <= r_phase;
      // Frame/line pulses last exactly one clk: cleared on every edge
      // unless this edge advances the raster.
      r_frame   <= 1'b0;
      r_line    <= 1'b0;
      if (r_phase) begin
        r_sx     <= w_sx_nx;
        r_sy     <= w_sy_nx;
        r_hsync  <= w_hs_act ? c_SYNC_ON : c_SYNC_OFF;
        r_vsync  <= w_vs_act ? c_SYNC_ON : c_SYNC_OFF;
        r_de     <= (w_sx_nx < c_H_RES) && (w_sy_nx < c_V_RES);
        r_vblank <= (w_sy_nx >= c_V_RES);
        r_frame  <= (w_sx_nx == '0) && (w_sy_nx == '0);
        r_line   <= (w_sx_nx == '0);
      end
    end
  end

  assign o_pix_stb = r_pix_stb;
  assign o_sx      = r_sx;
  assign o_sy      = r_sy;
  assign o_hsync   = r_hsync;
  assign o_vsync   = r_vsync;
  assign o_de      = r_de;
  assign o_vblank  = r_vblank;
  assign o_frame   = r_frame;
  assign o_line    = r_line;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed self-checking bench. u_dut0 uses the default 640x480
//               timing (reset release, hsync window, line spacing); u_dut1 is
//               a reduced 25x19 raster with active-high syncs and CW=6 so that
//               whole frames, wraps and mid-frame reset fit a short run.
//               u_dut1 raster: H 16/2/4/3 (sync sx 18..21), V 12/2/2/3
//               (sync sy 14..15), frame = 2*25*19 = 950 clks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst0, rst1;

  logic       p0_stb, p0_hs, p0_vs, p0_de, p0_vb, p0_fr, p0_ln;
  logic [9:0] p0_sx, p0_sy;
  logic       p1_stb, p1_hs, p1_vs, p1_de, p1_vb, p1_fr, p1_ln;
  logic [5:0] p1_sx, p1_sy;

  vga_timing_gen u_dut0 (
    .clk(clk), .rst(rst0), .o_pix_stb(p0_stb), .o_sx(p0_sx), .o_sy(p0_sy),
    .o_hsync(p0_hs), .o_vsync(p0_vs), .o_de(p0_de), .o_vblank(p0_vb),
    .o_frame(p0_fr), .o_line(p0_ln)
  );

  vga_timing_gen #(
    .H_RES(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_RES(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1), .CW(6)
  ) u_dut1 (
    .clk(clk), .rst(rst1), .o_pix_stb(p1_stb), .o_sx(p1_sx), .o_sy(p1_sy),
    .o_hsync(p1_hs), .o_vsync(p1_vs), .o_de(p1_de), .o_vblank(p1_vb),
    .o_frame(p1_fr), .o_line(p1_ln)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Advance one clk and sample on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int   cyc, last_ln, hs_lo, hs_lo_win, stb_bad, fr_cnt, vs_lo;
    logic hs655, hs752, de639, de640;
    int   last_fr, n_fr, de_cnt, hs_cnt, hs_out, vs_cnt, vs_out, vb_cnt, vb_bad, pulse_bad;
    int   prev_sx, prev_sy, found;
    bit   done_wrap, done_line;

    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (3) step();

    // Reset state
    chk("rst_stb",    p0_stb, 0);
    chk("rst_sx",     p0_sx, 799);
    chk("rst_sy",     p0_sy, 524);
    chk("rst_de",     p0_de, 0);
    chk("rst_vblank", p0_vb, 1);
    chk("rst_hsync",  p0_hs, 1);
    chk("rst_vsync",  p0_vs, 1);
    chk("rst_frame",  p0_fr, 0);
    chk("rst_line",   p0_ln, 0);
    chk("rst1_sx",    p1_sx, 24);
    chk("rst1_sy",    p1_sy, 18);
    chk("rst1_hsync", p1_hs, 0);
    chk("rst1_vsync", p1_vs, 0);

    // Reset release on the default raster
    rst0 = 1'b0;
    step();
    chk("rel1_stb", p0_stb, 0);
    chk("rel1_sx",  p0_sx, 799);
    step();
    chk("rel2_stb",    p0_stb, 1);
    chk("rel2_sx",     p0_sx, 0);
    chk("rel2_sy",     p0_sy, 0);
    chk("rel2_de",     p0_de, 1);
    chk("rel2_vblank", p0_vb, 0);
    chk("rel2_frame",  p0_fr, 1);
    chk("rel2_line",   p0_ln, 1);
    chk("rel2_hsync",  p0_hs, 1);
    chk("rel2_vsync",  p0_vs, 1);

    // Run through line 10 of the default raster
    cyc = 0; last_ln = 0; hs_lo = 0; hs_lo_win = 0; stb_bad = 0; fr_cnt = 0; vs_lo = 0;
    hs655 = 1'bx; hs752 = 1'bx; de639 = 1'bx; de640 = 1'bx;
    while (cyc < 20000) begin
      step();
      cyc++;
      if (p0_stb !== ((cyc % 2) == 0)) stb_bad++;
      if (p0_fr) fr_cnt++;
      if (!p0_vs) vs_lo++;
      if (p0_ln) begin
        chk("line_gap", cyc - last_ln, 1600);
        last_ln = cyc;
      end
      if (p0_stb && p0_sy == 10) begin
        if (!p0_hs) begin
          hs_lo++;
          if (p0_sx >= 656 && p0_sx <= 751) hs_lo_win++;
        end
        if (p0_sx == 655) hs655 = p0_hs;
        if (p0_sx == 752) hs752 = p0_hs;
        if (p0_sx == 639) de639 = p0_de;
        if (p0_sx == 640) de640 = p0_de;
      end
      if (p0_stb && p0_sy == 11) break;
    end
    chk("d0_reach_line11", p0_sy, 11);
    chk("stb_alternate_errs", stb_bad, 0);
    chk("d0_no_frame", fr_cnt, 0);
    chk("d0_no_vsync", vs_lo, 0);
    chk("hs_lo_count", hs_lo, 96);
    chk("hs_lo_in_window", hs_lo_win, 96);
    chk("hs_at_655", hs655, 1);
    chk("hs_at_752", hs752, 1);
    chk("de_at_639", de639, 1);
    chk("de_at_640", de640, 0);
    rst0 = 1'b1;

    // Reduced raster: release and two full frames
    rst1 = 1'b0;
    step();
    chk("d1_rel1_stb", p1_stb, 0);
    step();
    chk("d1_rel2_stb",   p1_stb, 1);
    chk("d1_rel2_sx",    p1_sx, 0);
    chk("d1_rel2_sy",    p1_sy, 0);
    chk("d1_rel2_frame", p1_fr, 1);
    chk("d1_rel2_hsync", p1_hs, 0);

    cyc = 0; last_fr = 0; n_fr = 0; de_cnt = 0; hs_cnt = 0; hs_out = 0;
    vs_cnt = 0; vs_out = 0; vb_cnt = 0; vb_bad = 0; pulse_bad = 0;
    prev_sx = 0; prev_sy = 0; done_wrap = 1'b0; done_line = 1'b0;
    // Count the (0,0) strobe of the first frame
    de_cnt = 1;
    while (cyc < 2500) begin
      step();
      cyc++;
      if (!p1_stb && (p1_fr || p1_ln)) pulse_bad++;
      if (p1_fr) begin
        chk("frame_gap", cyc - last_fr, 950);
        last_fr = cyc;
        n_fr++;
      end
      if (p1_stb) begin
        if (prev_sx == 24 && prev_sy == 18 && !done_wrap) begin
          chk("wrap_sx",     p1_sx, 0);
          chk("wrap_sy",     p1_sy, 0);
          chk("wrap_frame",  p1_fr, 1);
          chk("wrap_vblank", p1_vb, 0);
          done_wrap = 1'b1;
        end
        if (prev_sx == 24 && prev_sy == 5 && !done_line) begin
          chk("lwrap_sx",    p1_sx, 0);
          chk("lwrap_sy",    p1_sy, 6);
          chk("lwrap_line",  p1_ln, 1);
          chk("lwrap_frame", p1_fr, 0);
          done_line = 1'b1;
        end
        if (cyc < 950) begin
          if (p1_de) de_cnt++;
          if (p1_hs) begin
            hs_cnt++;
            if (p1_sx < 18 || p1_sx > 21) hs_out++;
          end
          if (p1_vs) begin
            vs_cnt++;
            if (p1_sy < 14 || p1_sy > 15) vs_out++;
          end
          if (p1_vb) vb_cnt++;
          if (p1_vb !== (p1_sy >= 12)) vb_bad++;
        end
        prev_sx = int'(p1_sx);
        prev_sy = int'(p1_sy);
      end
      if (n_fr == 2) break;
    end
    chk("d1_two_frames",  n_fr, 2);
    chk("d1_wrap_seen",   done_wrap, 1);
    chk("d1_lwrap_seen",  done_line, 1);
    chk("d1_de_count",    de_cnt, 192);
    chk("d1_hs_count",    hs_cnt, 76);
    chk("d1_hs_outside",  hs_out, 0);
    chk("d1_vs_count",    vs_cnt, 50);
    chk("d1_vs_outside",  vs_out, 0);
    chk("d1_vb_count",    vb_cnt, 175);
    chk("d1_vb_errs",     vb_bad, 0);
    chk("d1_pulse_width", pulse_bad, 0);

    // Mid-frame reset on the edge that would otherwise advance from (10,7)
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (p1_stb && p1_sx == 10 && p1_sy == 7) begin
        found = 1;
        break;
      end
    end
    chk("mid_found", found, 1);
    step();
    rst1 = 1'b1;
    step();
    chk("mid_sx",    p1_sx, 24);
    chk("mid_sy",    p1_sy, 18);
    chk("mid_de",    p1_de, 0);
    chk("mid_stb",   p1_stb, 0);
    chk("mid_vblank", p1_vb, 1);
    rst1 = 1'b0;
    step();
    chk("mid_rel1_stb", p1_stb, 0);
    step();
    chk("mid_rel2_stb",   p1_stb, 1);
    chk("mid_rel2_sx",    p1_sx, 0);
    chk("mid_rel2_sy",    p1_sy, 0);
    chk("mid_rel2_frame", p1_fr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
